// File: rtl/uc_pkg.sv
// Shared definitions for the control unit: opcodes, step encodings and default widths.
package uc_pkg;

   localparam int unsigned DEF_DATA_W  = 9;
   localparam int unsigned DEF_REG_SEL = 3;
   localparam int unsigned OPC_W       = 3;

   localparam logic [OPC_W-1:0] OP_MV  = 3'b000;
   localparam logic [OPC_W-1:0] OP_MVI = 3'b001;
   localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
   localparam logic [OPC_W-1:0] OP_SUB = 3'b011;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_e;

endpackage

// File: rtl/unidade_controle_dec3to8.sv
// Register-select decoder: binary select to one-hot, all zeros when disabled.
module dec3to8 #(
   parameter int unsigned SelW = 3
) (
   input  logic [SelW-1:0]     sel_i,
   input  logic                en_i,
   output logic [2**SelW-1:0]  onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[sel_i] = 1'b1;
      end
   end

endmodule

// File: rtl/unidade_controle.sv
// Control unit of the simple processor: step counter, IR and opcode/step decode.
// Optional macro UC_ILLEGAL_TRAP_EN: opcode 1xx freezes the unit in T1 and sets a sticky Illegal.
module unidade_controle
   import uc_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned REG_SEL = DEF_REG_SEL
) (
   input  logic                    Clock,
   input  logic                    Resetn,
   input  logic                    Run,
   input  logic [DATA_W-1:0]       DIN,
   output logic                    IRin,
   output logic [2**REG_SEL-1:0]   Rin,
   output logic [2**REG_SEL-1:0]   Rout,
   output logic                    Ain,
   output logic                    Gin,
   output logic                    Gout,
   output logic                    DINout,
   output logic                    AddSub,
   output logic                    Done,
   output logic                    Illegal
);

   step_e               step_q, step_d;
   logic [DATA_W-1:0]   ir_q, ir_d;

   logic [OPC_W-1:0]    opcode;
   logic [REG_SEL-1:0]  rx, ry, rout_sel;
   logic                rin_en, rout_en, rout_rx;

   assign opcode = ir_q[DATA_W-1 -: OPC_W];
   assign rx     = ir_q[2*REG_SEL-1 -: REG_SEL];
   assign ry     = ir_q[REG_SEL-1:0];

`ifdef UC_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   assign Illegal = illegal_q;
`else
   assign Illegal = 1'b0;
`endif

   always_comb begin
      step_d  = step_q;
      ir_d    = ir_q;
      IRin    = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      DINout  = 1'b0;
      AddSub  = 1'b0;
      Done    = 1'b0;
      rin_en  = 1'b0;
      rout_en = 1'b0;
      rout_rx = 1'b0;
`ifdef UC_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif

      unique case (step_q)
         T0: begin
            // Gated by Resetn so a held Run cannot leak IRin during reset.
            if (Run && Resetn) begin
               IRin   = 1'b1;
               ir_d   = DIN;
               step_d = T1;
            end
         end
         T1: begin
            case (opcode)
               OP_MV: begin
                  rout_en = 1'b1;
                  rin_en  = 1'b1;
                  Done    = 1'b1;
               end
               OP_MVI: begin
                  DINout = 1'b1;
                  rin_en = 1'b1;
                  Done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout_en = 1'b1;
                  rout_rx = 1'b1;
                  Ain     = 1'b1;
                  step_d  = T2;
               end
               default: begin
`ifdef UC_ILLEGAL_TRAP_EN
                  illegal_d = 1'b1;
`else
                  Done = 1'b1;
`endif
               end
            endcase
         end
         T2: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               rout_en = 1'b1;
               Gin     = 1'b1;
               AddSub  = opcode[0];
               step_d  = T3;
            end else begin
               step_d = T0;
            end
         end
         T3: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               Gout   = 1'b1;
               rin_en = 1'b1;
               Done   = 1'b1;
            end else begin
               step_d = T0;
            end
         end
         default: step_d = T0;
      endcase

      if (Done) begin
         step_d = T0;
      end
   end

   assign rout_sel = rout_rx ? rx : ry;

   dec3to8 #(
      .SelW (REG_SEL)
   ) u_dec_rx (
      .sel_i    (rx),
      .en_i     (rin_en),
      .onehot_o (Rin)
   );

   dec3to8 #(
      .SelW (REG_SEL)
   ) u_dec_ry (
      .sel_i    (rout_sel),
      .en_i     (rout_en),
      .onehot_o (Rout)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         step_q <= T0;
         ir_q   <= '0;
      end else begin
         step_q <= step_d;
         ir_q   <= ir_d;
      end
   end

`ifdef UC_ILLEGAL_TRAP_EN
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed vector table, corner sequences, random run.
module tb_unidade_controle;

   typedef logic [23:0] ov_t;

   typedef struct {
      bit         rstn;
      bit         run;
      logic [8:0] din;
      ov_t        exp;
      string      name;
   } vec_t;

   logic       Clock, Resetn, Run;
   logic [8:0] DIN;
   logic       IRin, Ain, Gin, Gout, DINout, AddSub, Done, Illegal;
   logic [7:0] Rin, Rout;

   int n_total;
   int n_pass;
   vec_t vecs[$];
   ov_t  q_exp[$];

   unidade_controle dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .Run     (Run),
      .DIN     (DIN),
      .IRin    (IRin),
      .Rin     (Rin),
      .Rout    (Rout),
      .Ain     (Ain),
      .Gin     (Gin),
      .Gout    (Gout),
      .DINout  (DINout),
      .AddSub  (AddSub),
      .Done    (Done),
      .Illegal (Illegal)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic ov_t mk(input bit irin, input logic [7:0] rin, input logic [7:0] rout,
                              input bit ain, input bit gin, input bit gout, input bit dinout,
                              input bit addsub, input bit done, input bit ill);
      return {irin, rin, rout, ain, gin, gout, dinout, addsub, done, ill};
   endfunction

   function automatic logic [7:0] bitof(input logic [2:0] r);
      logic [7:0] one;
      one = 8'h01;
      return one << r;
   endfunction

   task automatic check(input string name, input ov_t exp);
      ov_t act;
      act = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Illegal};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step(input bit rstn, input bit run, input logic [8:0] din, input ov_t exp,
                       input string name);
      @(negedge Clock);
      Resetn = rstn;
      Run    = run;
      DIN    = din;
      #1;
      check(name, exp);
   endtask

   task automatic addv(input bit rstn, input bit run, input logic [8:0] din, input ov_t exp,
                       input string name);
      vec_t v;
      v.rstn = rstn;
      v.run  = run;
      v.din  = din;
      v.exp  = exp;
      v.name = name;
      vecs.push_back(v);
   endtask

   // Reference: each fetched instruction expands into its list of per-step output words.
   task automatic model_fetch(input logic [8:0] w);
      logic [2:0] op, rx, ry;
      op = w[8:6];
      rx = w[5:3];
      ry = w[2:0];
      case (op)
         3'd0: q_exp.push_back(mk(0, bitof(rx), bitof(ry), 0, 0, 0, 0, 0, 1, 0));
         3'd1: q_exp.push_back(mk(0, bitof(rx), 8'h00, 0, 0, 0, 1, 0, 1, 0));
         3'd2, 3'd3: begin
            q_exp.push_back(mk(0, 8'h00, bitof(rx), 1, 0, 0, 0, 0, 0, 0));
            q_exp.push_back(mk(0, 8'h00, bitof(ry), 0, 1, 0, 0, op[0], 0, 0));
            q_exp.push_back(mk(0, bitof(rx), 8'h00, 0, 0, 1, 0, 0, 1, 0));
         end
         default: q_exp.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0));
      endcase
   endtask

   localparam ov_t Z = 24'h0;

   initial begin
      n_total = 0;
      n_pass  = 0;
      Resetn  = 1'b0;
      Run     = 1'b0;
      DIN     = 9'h0;
      repeat (2) @(negedge Clock);

      // Directed vector table
      addv(0, 1, 9'o101, Z, "rst_hold0");
      addv(0, 1, 9'o101, Z, "rst_hold1");
      addv(1, 1, 9'o101, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_rel_fetch");
      addv(1, 0, 9'o000, mk(0, 8'h01, 0, 0, 0, 0, 1, 0, 1, 0), "mvi_r0_t1");
      addv(1, 1, 9'o110, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mvi_r1_fetch");
      addv(1, 0, 9'd5,   mk(0, 8'h02, 0, 0, 0, 0, 1, 0, 1, 0), "mvi_r1_t1");
      addv(1, 0, 9'o000, Z, "idle_t0");
      addv(1, 1, 9'o201, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add_fetch");
      addv(1, 0, 9'o000, mk(0, 0, 8'h01, 1, 0, 0, 0, 0, 0, 0), "add_t1");
      addv(1, 0, 9'o000, mk(0, 0, 8'h02, 0, 1, 0, 0, 0, 0, 0), "add_t2");
      addv(1, 0, 9'o000, mk(0, 8'h01, 0, 0, 0, 1, 0, 0, 1, 0), "add_t3");
      addv(1, 1, 9'o333, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sub_fetch");
      addv(1, 1, 9'o333, mk(0, 0, 8'h08, 1, 0, 0, 0, 0, 0, 0), "sub_t1");
      addv(1, 1, 9'o333, mk(0, 0, 8'h08, 0, 1, 0, 0, 1, 0, 0), "sub_t2");
      addv(1, 1, 9'o023, mk(0, 8'h08, 0, 0, 0, 1, 0, 0, 1, 0), "sub_t3");
      addv(1, 1, 9'o023, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "b2b_mv_fetch");
      addv(1, 0, 9'o000, mk(0, 8'h04, 8'h08, 0, 0, 0, 0, 0, 1, 0), "mv_r2_r3");
      addv(1, 0, 9'o000, Z, "after_mv");
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rstn, vecs[i].run, vecs[i].din, vecs[i].exp, vecs[i].name);
      end

      // Reset pulse in the middle of an add
      step(1, 1, 9'o201, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort_fetch");
      step(1, 0, 9'o000, mk(0, 0, 8'h01, 1, 0, 0, 0, 0, 0, 0), "abort_t1");
      step(0, 0, 9'o000, Z, "abort_in_t2");
      step(1, 0, 9'o000, Z, "abort_after0");
      step(1, 0, 9'o000, Z, "abort_after1");
      step(1, 1, 9'o110, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort_refetch");
      step(1, 0, 9'o000, mk(0, 8'h02, 0, 0, 0, 0, 1, 0, 1, 0), "abort_refetch_t1");

      // Undefined opcode
      step(1, 1, 9'o400, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_fetch");
`ifdef UC_ILLEGAL_TRAP_EN
      step(1, 1, 9'o000, Z, "ill_t1");
      step(1, 1, 9'o000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_sticky0");
      step(1, 1, 9'o110, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_sticky1");
      step(1, 1, 9'o110, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_sticky2");
      step(0, 0, 9'o000, Z, "ill_reset");
      step(1, 0, 9'o000, Z, "ill_cleared");
`else
      step(1, 1, 9'o110, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "nop_t1");
      step(1, 1, 9'o110, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "nop_next_fetch");
      step(1, 0, 9'o000, mk(0, 8'h02, 0, 0, 0, 0, 1, 0, 1, 0), "nop_next_t1");
`endif

      // Random stimulus against the instruction-level model
      step(1, 0, 9'o000, Z, "rand_start_idle");
      q_exp.delete();
      for (int i = 0; i < 600; i++) begin
         bit         run;
         logic [8:0] din;
         ov_t        e;
         bit         idle;
         run = ($urandom_range(0, 3) != 0);
`ifdef UC_ILLEGAL_TRAP_EN
         din = {3'($urandom_range(0, 3)), 6'($urandom)};
`else
         din = {3'($urandom_range(0, 7)), 6'($urandom)};
`endif
         idle = (q_exp.size() == 0);
         if (idle) e = mk(run, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         else      e = q_exp.pop_front();
         step(1, run, din, e, "rand");
         if (idle && run) model_fetch(din);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
